// File: rtl/btn_bounce_gen.sv
// btn_bounce_gen: mechanical push-button emulator.
// Takes a clean level request and produces a bouncing raw button waveform:
// one edge to the new level, then 0..2^PAIRS_W-1 away/back glitch pairs with
// pseudo-random spacing, then a fixed settle hold before a done pulse.
// Optional macro BTN_BOUNCE_GEN_TICK_EN adds a 'tick' strobe input; when it is
// defined the gap and settle counters advance only on tick cycles, otherwise
// they advance every clk cycle.
// The LFSR fields used must fit in 16 bits: GAP_W + PAIRS_W <= 16.
module btn_bounce_gen #(
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          GAP_W      = 12,
   parameter int          PAIRS_W    = 3,
   parameter int          SETTLE_CYC = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic level,
`ifdef BTN_BOUNCE_GEN_TICK_EN
   input  logic tick,
`endif
   output logic btn_out,
   output logic busy,
   output logic done
);

   localparam int          SW   = $clog2(SETTLE_CYC + 1);
   // An all-zero seed would lock the LFSR up, so it is replaced by 1.
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

   state_t               state;
   logic [15:0]          lfsr;
   logic                 target;
   logic [PAIRS_W-1:0]   pairs;
   logic [GAP_W:0]       gap;       // one extra bit so 2^GAP_W is representable
   logic [SW-1:0]        settle;
   logic [GAP_W:0]       gap_load;
   logic [PAIRS_W-1:0]   pairs_load;
   logic                 unit;

`ifdef BTN_BOUNCE_GEN_TICK_EN
   assign unit = tick;
`else
   assign unit = 1'b1;
`endif

   // Gap is 1..2^GAP_W units; pair count is 0..2^PAIRS_W-1.
   assign gap_load   = {1'b0, lfsr[GAP_W+PAIRS_W-1:PAIRS_W]} + {{GAP_W{1'b0}}, 1'b1};
   assign pairs_load = lfsr[PAIRS_W-1:0];

   // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1, advances every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr <= SEED;
      else
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   // Sequence FSM with registered button, busy and done outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         btn_out <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         target  <= 1'b0;
         pairs   <= '0;
         gap     <= '0;
         settle  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy   <= 1'b1;
                  target <= level;
                  settle <= SW'(SETTLE_CYC);
                  if (level != btn_out) begin
                     // First edge lands directly on the target level.
                     btn_out <= level;
                     pairs   <= pairs_load;
                     gap     <= gap_load;
                     state   <= (pairs_load != '0) ? BOUNCE : SETTLE;
                  end else begin
                     state <= SETTLE;
                  end
               end
            end
            BOUNCE: begin
               if (unit) begin
                  if (gap == (GAP_W+1)'(1)) begin
                     btn_out <= ~btn_out;
                     gap     <= gap_load;
                     // A toggle from the away level completes one glitch pair.
                     if (btn_out != target) begin
                        pairs <= pairs - PAIRS_W'(1);
                        if (pairs == PAIRS_W'(1)) begin
                           settle <= SW'(SETTLE_CYC);
                           state  <= SETTLE;
                        end
                     end
                  end else begin
                     gap <= gap - (GAP_W+1)'(1);
                  end
               end
            end
            SETTLE: begin
               if (unit) begin
                  settle <= settle - SW'(1);
                  if (settle == SW'(1)) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_btn_bounce_gen.sv
// tb_btn_bounce_gen: directed bench for btn_bounce_gen.
// A reference LFSR tracks the DUT's LFSR from reset so every edge time and the
// done time of a sequence are predicted exactly before the sequence runs.
// Gap and settle lengths are shrunk (GAP_W=6, SETTLE_CYC=256) to keep runs short.
// With BTN_BOUNCE_GEN_TICK_EN defined, tick is driven on every 8th edge.
module tb_btn_bounce_gen;

   localparam int TG     = 6;
   localparam int TP     = 3;
   localparam int TS     = 256;
   localparam int TICK_P = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic level;
   logic btn_out;
   logic busy;
   logic done;

`ifdef BTN_BOUNCE_GEN_TICK_EN
   logic tick;
   bit   tick_en = 1'b1;
`endif

   int          cyc = 0;
   logic [15:0] ml;
   logic        prev_btn = 1'b0;
   logic        busy_at_done = 1'b1;
   logic        exp_btn;
   int          edge_q[$];
   int          done_q[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   btn_bounce_gen #(
      .LFSR_SEED  (16'hACE1),
      .GAP_W      (TG),
      .PAIRS_W    (TP),
      .SETTLE_CYC (TS)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .level   (level),
`ifdef BTN_BOUNCE_GEN_TICK_EN
      .tick    (tick),
`endif
      .btn_out (btn_out),
      .busy    (busy),
      .done    (done)
   );

`ifdef BTN_BOUNCE_GEN_TICK_EN
   // Tick is seen by the DUT at edges whose number is a multiple of TICK_P.
   assign tick = tick_en && (((cyc + 1) % TICK_P) == 0);
`endif

   function automatic logic [15:0] lstep(input logic [15:0] v);
      logic [15:0] s;
      s = v >> 1;
      if (v[0]) s = s ^ 16'hB400;
      return s;
   endfunction

   function automatic logic [15:0] lstep_n(input logic [15:0] v, input int n);
      logic [15:0] s;
      s = v;
      for (int i = 0; i < n; i++) s = lstep(s);
      return s;
   endfunction

   function automatic int gap_of(input logic [15:0] v);
      return int'(v[TG+TP-1:TP]) + 1;
   endfunction

   // Edge number reached u units after edge t.
   function automatic int adv(input int t, input int u);
`ifdef BTN_BOUNCE_GEN_TICK_EN
      return ((t / TICK_P) + 1) * TICK_P + (u - 1) * TICK_P;
`else
      return t + u;
`endif
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Edge counter and reference LFSR.
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ml <= 16'hACE1;
      else        ml <= lstep(ml);
   end

   // Record edge numbers of btn_out changes and done pulses.
   always @(negedge clk) begin
      if (rst_n && btn_out != prev_btn) edge_q.push_back(cyc);
      if (rst_n && done) begin
         done_q.push_back(cyc);
         busy_at_done <= busy;
      end
      prev_btn <= btn_out;
   end

   // One full request: predict, drive, wait for done, compare.
   task automatic run_seq(input logic lvl, input bit ign, input string tag);
      int          pe[$];
      int          e0, t, g, p, dt, lim, n, sp;
      logic [15:0] l;
      @(posedge clk); #1;
`ifdef BTN_BOUNCE_GEN_TICK_EN
      while (((cyc + 1) % TICK_P) != 0) begin @(posedge clk); #1; end
`endif
      e0 = cyc + 1;
      l  = ml;
      edge_q.delete();
      done_q.delete();
      start = 1'b1;
      level = lvl;
      t = e0;
      if (lvl != exp_btn) begin
         pe.push_back(e0);
         p = int'(l[TP-1:0]);
         g = gap_of(l);
         for (int k = 0; k < 2 * p; k++) begin
            t = adv(t, g);
            pe.push_back(t);
            g = gap_of(lstep_n(l, t - e0));
         end
      end
      dt = adv(t, TS);
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "/busy_rise"}, busy, 1);
      chk({tag, "/first_lvl"}, btn_out, lvl);
      lim = dt - e0 + 100;
      for (int k = 0; k < lim && done_q.size() == 0; k++) begin
         @(negedge clk);
         if (ign && k == 0) begin start = 1'b1; level = ~lvl; end
         else if (ign && k == 1) start = 1'b0;
      end
      repeat (4) @(negedge clk);
      chk({tag, "/done_cnt"}, done_q.size(), 1);
      if (done_q.size() > 0) chk({tag, "/done_t"}, done_q[0], dt);
      chk({tag, "/edges"}, edge_q.size(), pe.size());
      n = (edge_q.size() < pe.size()) ? edge_q.size() : pe.size();
      for (int i = 0; i < n; i++) chk({tag, "/edge_t"}, edge_q[i], pe[i]);
      chk({tag, "/max15"}, int'(edge_q.size() <= 15), 1);
      for (int i = 1; i < edge_q.size(); i++) begin
         sp = edge_q[i] - edge_q[i-1];
`ifdef BTN_BOUNCE_GEN_TICK_EN
         chk({tag, "/sp_mul8"}, sp % TICK_P, 0);
         sp = sp / TICK_P;
`endif
         chk({tag, "/sp_range"}, int'(sp >= 1 && sp <= (1 << TG)), 1);
      end
      chk({tag, "/busy_at_done"}, busy_at_done, 0);
      chk({tag, "/busy_after"}, busy, 0);
      chk({tag, "/final"}, btn_out, lvl);
      exp_btn = lvl;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      level   = 1'b0;
      exp_btn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst/btn", btn_out, 0);
      chk("rst/busy", busy, 0);
      chk("rst/done", done, 0);
      @(negedge clk) rst_n = 1'b1;
      edge_q.delete();
      repeat (20) @(posedge clk);
      #1;
      chk("idle/edges", edge_q.size(), 0);
      chk("idle/busy", busy, 0);

      run_seq(1'b1, 1'b0, "up");
      run_seq(1'b1, 1'b0, "same");
      run_seq(1'b0, 1'b0, "down");
      run_seq(1'b1, 1'b1, "ign_up");
      run_seq(1'b0, 1'b1, "ign_down");

      // Reset in the middle of a rising sequence.
      @(posedge clk); #1;
      done_q.delete();
      start = 1'b1;
      level = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("rst_mid/pre_btn", btn_out, 1);
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b0;
      #1;
      chk("rst_mid/btn", btn_out, 0);
      chk("rst_mid/busy", busy, 0);
      repeat (4) @(negedge clk);
      chk("rst_mid/no_done", done_q.size(), 0);
      rst_n = 1'b1;
      exp_btn = 1'b0;
      run_seq(1'b1, 1'b0, "fresh");

`ifdef BTN_BOUNCE_GEN_TICK_EN
      // With tick held low the waveform must freeze after the first edge.
      tick_en = 1'b0;
      @(posedge clk); #1;
      edge_q.delete();
      done_q.delete();
      start = 1'b1;
      level = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (200) @(negedge clk);
      chk("freeze/edges", edge_q.size(), 1);
      chk("freeze/btn", btn_out, 0);
      chk("freeze/busy", busy, 1);
      tick_en = 1'b1;
      for (int k = 0; k < 20000 && done_q.size() == 0; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("freeze/done_cnt", done_q.size(), 1);
      chk("freeze/final", btn_out, 0);
      chk("freeze/odd", edge_q.size() % 2, 1);
      exp_btn = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_bounce_gen.md
# btn_bounce_gen

Synthesizable mechanical-button emulator: converts a clean level request into a bouncing, glitchy button waveform that then settles at the requested level. It is the driving end of the button-input path. Its `btn_out` feeds the debouncer's raw button input on-chip for self-test and in benches, so the debouncer is exercised by realistic, pseudo-random bounce without hand-written stimulus.

## Interface
Parameters:
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. An all-zero seed is replaced by 16'h0001.
- `GAP_W`, default 12: width of the random gap field. Each gap is 1..2^GAP_W units.
- `PAIRS_W`, default 3: width of the random glitch-pair count. Pair count is 0..2^PAIRS_W-1.
- `SETTLE_CYC`, default 4096: stable-hold length after the last edge, in units. Must be at least 1.

Ports:
- `clk`, input, 1: single clock; all state is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle request pulse.
- `level`, input, 1: target level, sampled with `start`.
- `tick`, input, 1: gap/settle unit strobe. Present only with `BTN_BOUNCE_GEN_TICK_EN`.
- `btn_out`, output, 1: emulated raw button, registered.
- `busy`, output, 1: high while a sequence is in progress.
- `done`, output, 1: one-cycle pulse when settling completes.

## Operation
- 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1. It advances every clk cycle, independent of state.
- States: IDLE, BOUNCE, SETTLE.
- IDLE, `start`=1, `level`≠`btn_out`:
  - Toggle `btn_out` (first edge, now at target).
  - Load `pairs` = lfsr[PAIRS_W-1:0] and `gap` = lfsr[GAP_W+PAIRS_W-1:PAIRS_W] + 1.
  - Go to BOUNCE if `pairs`≠0, else SETTLE.
- IDLE, `start`=1, `level`=`btn_out`: no edge. Go directly to SETTLE.
- BOUNCE:
  - Decrement `gap` each unit.
  - On reaching 0, toggle `btn_out` and reload `gap` from the current LFSR (same bit field, +1).
  - Every second toggle (`btn_out` back at target) decrements `pairs`. When `pairs` hits 0, go to SETTLE.
  - Total edges per sequence = 1 + 2·pairs (always odd). Final `btn_out` equals target.
- SETTLE:
  - Load counter with SETTLE_CYC on entry, decrement each unit.
  - At 0: pulse `done` for one cycle and return to IDLE.
  - `btn_out` is constant throughout.
- A `start` while `busy`=1 is ignored, and its `level` is discarded.
- `gap` arithmetic is GAP_W+1 bits wide, so 2^GAP_W fits without wrap.
- Reset mid-sequence: everything returns to reset values immediately. No `done` pulse.

## Timing
- Reset values: `btn_out`=0, `busy`=0, `done`=0, state IDLE, LFSR=`LFSR_SEED`.
- `start` sampled at edge N: the first `btn_out` edge and `busy`=1 are visible after edge N+1 (latency 1).
- One unit is one clk cycle without the macro, or one cycle with `tick`=1 with the macro.
- Successive BOUNCE edges are exactly `gap` units apart.
- Last edge to `done`: exactly SETTLE_CYC units. In the no-edge case, `start` to `done` is SETTLE_CYC units plus 1 cycle.
- `busy` falls in the same cycle `done` is high.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- `BTN_BOUNCE_GEN_TICK_EN` defined:
  - The `tick` port exists.
  - Gap and settle counters decrement only on cycles with `tick`=1, matching the debouncer's sampling-tick timescale.
  - State transitions and `done` still occur on the clk edge where the counter reaches 0.
- Undefined:
  - No `tick` port.
  - Counters decrement every clk cycle.

## Test plan
- Reset: assert `rst_n`=0 for 3 cycles. Expect `btn_out`=0, `busy`=0, `done`=0. Release: no activity without `start`.
- `start`, `level`=1 (defaults, macro off):
  - `btn_out` rises 1 cycle later.
  - Odd number of edges, at most 15.
  - Each inter-edge spacing between 1 and 4096 cycles.
  - `done` exactly 4096 cycles after the last edge; final `btn_out`=1.
- `start`, `level`=0 after the previous test: mirror behaviour, final `btn_out`=0. Bench model with the same LFSR predicts the exact edge times.
- `start`, `level`=1 while `btn_out`=1: zero edges; `done` 4097 cycles after `start`.
- `start` pulse mid-BOUNCE with the opposite level: ignored, and the final level equals the first request.
- Reset asserted mid-BOUNCE: `btn_out`=0 and `busy`=0 immediately, no `done`. A `start` after release behaves as a fresh sequence.
- Macro on, `tick` every 8 cycles: all spacings are multiples of 8 cycles; with `tick` held 0, `btn_out` freezes after the first edge.
